shot_arbiter: RTL

SHOT_ARBITER -- requirements
Module: shot_arbiter

---
 rtl/tank_pkg.sv | 39 +++
 rtl/shot_arbiter_if.sv | 37 +++
 rtl/shot_arbiter_rr_pick.sv | 23 ++
 rtl/shot_arbiter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared tank definitions: headings, tank geometry, arbiter state encoding.
// Spawn helpers place a bullet at the centre of a 32x32 tank sprite.
package tank_pkg;

  localparam int TANK_W = 32;
  localparam int TANK_H = 32;
  localparam int HALF   = 16;
  localparam int POS_W  = 10;
  localparam int IDX_W  = 2;

  typedef enum logic [2:0] {
    DIR_UP    = 3'd0,
    DIR_UR    = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_DR    = 3'd3,
    DIR_DOWN  = 3'd4,
    DIR_DL    = 3'd5,
    DIR_LEFT  = 3'd6,
    DIR_UL    = 3'd7
  } dir_t;

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } arb_state_t;

  function automatic logic [POS_W-1:0] spawn_x(
    input logic [POS_W-1:0] p
  );
    return p + POS_W'(TANK_W / 2);
  endfunction

  function automatic logic [POS_W-1:0] spawn_y(
    input logic [POS_W-1:0] p
  );
    return p + POS_W'(TANK_H / 2);
  endfunction

endpackage

// File: rtl/shot_arbiter_if.sv
// Launch bus from the shot arbiter to the bullet engines.
// One-cycle strobe carrying slot, owner, spawn point and heading.
interface shot_arbiter_if
  import tank_pkg::*;
#(
  parameter int N_TANKS = 4
);

  logic               launch_valid;
  logic [IDX_W-1:0]   launch_slot;
  logic [IDX_W-1:0]   launch_owner;
  logic [POS_W-1:0]   launch_X;
  logic [POS_W-1:0]   launch_Y;
  logic [2:0]         launch_dir;
  logic [N_TANKS-1:0] grant;

  modport master (
    output launch_valid,
    output launch_slot,
    output launch_owner,
    output launch_X,
    output launch_Y,
    output launch_dir,
    output grant
  );

  modport slave (
    input launch_valid,
    input launch_slot,
    input launch_owner,
    input launch_X,
    input launch_Y,
    input launch_dir,
    input grant
  );

endinterface

// File: rtl/shot_arbiter_rr_pick.sv
// Rotating priority pick: first set request at or after ptr, wrapping.
// With ptr tied to zero it degenerates to a lowest-set-bit finder.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    idx   = '0;
    found = |req;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/shot_arbiter.sv
// Grants tank fire requests onto shared bullet engines, round-robin,
// with per-tank frame cooldown and slot reservation until engines go busy.
module shot_arbiter
  import tank_pkg::*;
#(
  parameter int         N_TANKS  = 4,
  parameter int         N_SLOTS  = 4,
  parameter logic [7:0] COOLDOWN = 8'd30
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_clk,
  input  logic [N_TANKS-1:0]     fire_req,
  input  logic [10*N_TANKS-1:0]  tank_X_flat,
  input  logic [10*N_TANKS-1:0]  tank_Y_flat,
  input  logic [3*N_TANKS-1:0]   tank_dir_flat,
  input  logic [N_SLOTS-1:0]     slot_free,
  shot_arbiter_if.master         launch
);

  arb_state_t         state, state_n;
  logic               frame_d, frame_edge;
  logic [N_TANKS-1:0] pending;
  logic [7:0]         cooldown [N_TANKS];
  logic [N_SLOTS-1:0] reserved, avail, slot_set;
  logic [IDX_W-1:0]   rr_ptr, winner, slot;
  logic [IDX_W-1:0]   pick_tank, pick_slot, next_ptr;
  logic               tank_found, slot_found;
  logic               take, granting;
  logic [POS_W-1:0]   pos_x [N_TANKS];
  logic [POS_W-1:0]   pos_y [N_TANKS];
  logic [2:0]         hdg   [N_TANKS];

  always_comb begin
    for (int i = 0; i < N_TANKS; i++) begin
      pos_x[i] = tank_X_flat[10*i +: 10];
      pos_y[i] = tank_Y_flat[10*i +: 10];
      hdg[i]   = tank_dir_flat[3*i +: 3];
    end
  end

  assign avail = slot_free & ~reserved;

  rr_pick #(.N(N_TANKS), .IW(IDX_W)) u_tank_pick (
    .req   (pending),
    .ptr   (rr_ptr),
    .idx   (pick_tank),
    .found (tank_found)
  );

  rr_pick #(.N(N_SLOTS), .IW(IDX_W)) u_slot_pick (
    .req   (avail),
    .ptr   (IDX_W'(0)),
    .idx   (pick_slot),
    .found (slot_found)
  );

  assign granting = (state == S_GRANT);
  assign take     = (state == S_IDLE) && tank_found && slot_found;
  assign slot_set = granting ? (N_SLOTS'(1) << slot) : '0;
  assign next_ptr = (winner == IDX_W'(N_TANKS - 1)) ?
                    '0 : winner + IDX_W'(1);

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (take) state_n = S_GRANT;
      S_GRANT: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      winner <= '0;
      slot   <= '0;
    end else if (take) begin
      winner <= pick_tank;
      slot   <= pick_slot;
    end
  end

  // The grant's cooldown load outranks both fire latching and frame decrement.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_d    <= 1'b0;
      frame_edge <= 1'b0;
      pending    <= '0;
      reserved   <= '0;
      rr_ptr     <= '0;
      for (int i = 0; i < N_TANKS; i++) cooldown[i] <= '0;
    end else begin
      frame_d    <= frame_clk;
      frame_edge <= frame_clk & ~frame_d;
      reserved   <= (reserved | slot_set) & slot_free;
      if (granting) rr_ptr <= next_ptr;
      for (int i = 0; i < N_TANKS; i++) begin
        if (granting && winner == IDX_W'(i)) begin
          pending[i]  <= 1'b0;
          cooldown[i] <= COOLDOWN;
        end else begin
          if (fire_req[i] && cooldown[i] == 8'd0)
            pending[i] <= 1'b1;
          if (frame_edge && cooldown[i] != 8'd0)
            cooldown[i] <= cooldown[i] - 8'd1;
        end
      end
    end
  end

  always_comb begin
    launch.launch_valid = 1'b0;
    launch.grant        = '0;
    launch.launch_slot  = '0;
    launch.launch_owner = '0;
    launch.launch_X     = '0;
    launch.launch_Y     = '0;
    launch.launch_dir   = '0;
    if (granting) begin
      launch.launch_valid = 1'b1;
      launch.grant        = N_TANKS'(1) << winner;
      launch.launch_slot  = slot;
      launch.launch_owner = winner;
      launch.launch_X     = spawn_x(pos_x[winner]);
      launch.launch_Y     = spawn_y(pos_y[winner]);
      launch.launch_dir   = hdg[winner];
    end
  end

endmodule
